dcache_responder: RTL
=====================

# dcache_responder

Data-side responder for the MEM stage: accepts the MEM stage's read/write request (MemRead/MemWrite, address, store data, ALU_control), returns a full aligned word from a direct-mapped, write-through, no-write-allocate data cache, and stalls the pipeline via FREEZE on read misses and on every store. Misses and stores go to main memory over a req/ack handshake. MEM-side load alignment stays in the MEM stage; this block always returns the whole big-endian word.

## Interface
- INDEX_BITS, 6, number of lines = 2^INDEX_BITS
- LINE_WORDS, 4, 32-bit words per line (power of 2)
- CLK  input  1  clock, all state on posedge
- RESET  input  1  asynchronous, active-low reset
- MemRead_fMEM  input  1  load request from MEM stage
- MemWrite_fMEM  input  1  store request from MEM stage
- data_address_fMEM  input  32  byte address
- data_write_fMEM  input  32  store data, right-justified
- ALU_control_fMEM  input  6  selects store width
- data_read_2MEM  output  32  cached word at address (combinational)
- FREEZE  output  1  pipeline stall (combinational)
- mem_req  output  1  main-memory request, registered
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  32  word-aligned address (bits [1:0] = 0)
- mem_wdata  output  32  write data, byte-lane positioned
- mem_be  output  4  byte enables, bit 3 ↔ [31:24]
- mem_rdata  input  32  read data, valid with mem_ack
- mem_ack  input  1  completes current beat

## Operation
- Address split: offset [1:0], word [W+1:2] (W = log2 LINE_WORDS), index next INDEX_BITS, tag the rest. hit = valid[index] & tag match.
- States: IDLE, FILL, WRITE, WDONE.
- IDLE: MemWrite → WRITE (MemWrite wins if both asserted). Else MemRead & !hit → FILL, latch line base, beat=0. Else stay.
- FILL: mem_req=1, mem_we=0, mem_addr=line base + 4·beat. On mem_ack write mem_rdata into line word beat; beat==LINE_WORDS-1 → set valid and tag, go IDLE; else beat+1.
- WRITE: mem_req=1, mem_we=1, latched address/data/be. On mem_ack: if hit on latched address, merge enabled bytes into cached word; go WDONE.
- WDONE: one cycle, FREEZE=0 so the store retires; → IDLE.
- FREEZE = (state IDLE & (MemWrite | MemRead & !hit)) | state∈{FILL, WRITE}.
- Store width, big-endian: SB 6'b101000: be = 4'b1000 >> addr[1:0], byte replicated to all lanes. SH 6'b101001: be = addr[1] ? 4'b0011 : 4'b1100, halfword replicated. Any other code is SW: be = 4'b1111. Misaligned SH/SW ignore the low bits.
- data_read_2MEM = array word at index/word offset regardless of hit; meaningful only when FREEZE=0.

## Timing
- Reset (async, RESET=0): state IDLE, all valid bits 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, beat 0. FREEZE follows the formula (1 if a request is present, since everything misses).
- Read hit: 0 cycles, no stall.
- Read miss: mem_ack may be high in the same cycle as mem_req, giving 1 beat per cycle. Minimum stall is 1 + LINE_WORDS cycles (5 at default). The load completes in the first IDLE cycle after the fill.
- Store: minimum 2 frozen cycles (IDLE, WRITE), then WDONE unfrozen.
- mem_req, mem_addr, mem_we, mem_wdata and mem_be are stable from assertion until the cycle mem_ack is sampled high. mem_req may stay high across back-to-back fill beats.
- mem_ack while mem_req=0 is ignored.
- Reset mid-FILL/WRITE aborts immediately; the partially filled line stays invalid.
- The line being filled is not valid until its final beat.

## Structure
- Package dcache_pkg: state enum, store ALU_control constants (SB, SH), be-generation function, default parameters.
- Sub-module dcache_array: valid/tag/data storage. Valid bits reset; one read port (combinational) and one write port with byte enables. Both fill writes and store merges use the write port.

## Test plan
- Reset, then MemRead at 0x0000_0100 with a zero-wait memory returning 0x11,0x22,0x33,0x44 → FREEZE high for 5 cycles, mem_addr 0x100,0x104,0x108,0x10C, then data_read_2MEM=0x11.
- Read 0x104 after that fill → FREEZE=0 same cycle, data 0x22, no mem_req.
- SB 0xAB to 0x101 (hit) → mem_be=4'b0100, mem_wdata=0xABABABAB; after ack, a read of 0x100 returns 0x00AB0011.
- SW to uncached 0x2000 → single mem write, FREEZE 2 cycles, no fill, line at 0x2000 stays invalid.
- Memory ack delayed 3 cycles per beat on a miss → outputs held stable while waiting; FREEZE lasts 1 + 4·4 = 17 cycles.
- RESET pulsed low during beat 2 of a fill → mem_req drops asynchronously; a later read of the same line misses and refills from word 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the MEM-stage data-cache responder.
//   - default geometry (lines, words per line)
//   - controller state encoding
//   - store ALU_control codes and big-endian byte-enable / lane helpers
package dcache_pkg;

    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_LINE_WORDS = 4;

    localparam logic [5:0] ALU_SB = 6'b101000;
    localparam logic [5:0] ALU_SH = 6'b101001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WDONE = 2'd3
    } dc_state_e;

    // Big-endian lanes: byte offset 0 lives in [31:24] (be bit 3).
    // Misaligned halfword/word stores drop the low address bits.
    function automatic logic [3:0] store_be(input logic [5:0] alu, input logic [1:0] off);
        logic [3:0] be;
        case (alu)
            ALU_SB:  be = 4'b1000 >> off;
            ALU_SH:  be = off[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data arrives right-justified; replicate it so every enabled
    // lane already holds the right byte(s).
    function automatic logic [31:0] store_lanes(input logic [5:0] alu, input logic [31:0] data);
        logic [31:0] lanes;
        case (alu)
            ALU_SB:  lanes = {4{data[7:0]}};
            ALU_SH:  lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for a direct-mapped cache.
//   clk_i, rst_ni        clock, async active-low reset (clears valid bits only)
//   rd_index_i/rd_word_i combinational read port -> rd_valid_o, rd_tag_o, rd_data_o
//   wr_en_i/wr_be_i      byte-enabled data write at wr_index_i/wr_word_i
//   tag_set_i            mark line wr_index_i valid with tag_i
//   inval_i              mark line wr_index_i invalid (takes priority over tag_set_i)
module dcache_array #(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4,
    parameter int WORD_BITS  = $clog2(LINE_WORDS),
    parameter int TAG_BITS   = 32 - 2 - WORD_BITS - INDEX_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    input  logic [WORD_BITS-1:0]  rd_word_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [31:0]           rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [WORD_BITS-1:0]  wr_word_i,
    input  logic [3:0]            wr_be_i,
    input  logic [31:0]           wr_data_i,
    input  logic                  tag_set_i,
    input  logic [TAG_BITS-1:0]   tag_i,
    input  logic                  inval_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES*LINE_WORDS];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[{rd_index_i, rd_word_i}];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (inval_i) begin
            valid_q[wr_index_i] <= 1'b0;
        end else if (tag_set_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tag_set_i) begin
            tag_q[wr_index_i] <= tag_i;
        end
        if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    data_q[{wr_index_i, wr_word_i}][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: MEM-stage data responder with a direct-mapped,
// write-through, no-write-allocate cache.
//   CLK, RESET                 clock, async active-low reset
//   MemRead_fMEM/MemWrite_fMEM load/store request from MEM stage
//   data_address_fMEM          byte address; data_write_fMEM store data (right-justified)
//   ALU_control_fMEM           store width select (SB/SH, else SW)
//   data_read_2MEM             full cached word at address (combinational)
//   FREEZE                     pipeline stall (combinational)
//   mem_req/we/addr/wdata/be   registered main-memory request
//   mem_rdata/mem_ack          main-memory response
//   state_o                    controller state, for observation
// Memory handshake: a beat is offered by holding mem_req high with mem_we,
// mem_addr, mem_wdata and mem_be stable; it completes on the first rising
// clock edge where mem_ack is high. mem_ack with mem_req low is ignored.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead_fMEM,
    input  logic        MemWrite_fMEM,
    input  logic [31:0] data_address_fMEM,
    input  logic [31:0] data_write_fMEM,
    input  logic [5:0]  ALU_control_fMEM,
    output logic [31:0] data_read_2MEM,
    output logic        FREEZE,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  state_o
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int IDX_LSB   = WORD_BITS + 2;
    localparam int TAG_LSB   = IDX_LSB + INDEX_BITS;
    localparam int TAG_BITS  = 32 - TAG_LSB;

    dc_state_e             state_q, state_d;
    logic [WORD_BITS-1:0]  beat_q, beat_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q, mem_be_d;

    // Lookup port: in WRITE the latched store address decides whether the
    // cached copy must be merged; otherwise the live MEM-stage address.
    logic [INDEX_BITS-1:0] lk_index;
    logic [WORD_BITS-1:0]  lk_word;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;

    logic                  arr_we;
    logic [INDEX_BITS-1:0] arr_index;
    logic [WORD_BITS-1:0]  arr_word;
    logic [3:0]            arr_be;
    logic [31:0]           arr_wdata;
    logic                  arr_tag_set;
    logic                  arr_inval;
    logic                  ack;

    always_comb begin
        if (state_q == ST_WRITE) begin
            lk_index = mem_addr_q[TAG_LSB-1:IDX_LSB];
            lk_word  = mem_addr_q[IDX_LSB-1:2];
            lk_tag   = mem_addr_q[31:TAG_LSB];
        end else begin
            lk_index = data_address_fMEM[TAG_LSB-1:IDX_LSB];
            lk_word  = data_address_fMEM[IDX_LSB-1:2];
            lk_tag   = data_address_fMEM[31:TAG_LSB];
        end
    end

    assign hit = rd_valid && (rd_tag == lk_tag);
    assign ack = mem_ack && mem_req_q;

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .LINE_WORDS (LINE_WORDS),
        .WORD_BITS  (WORD_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk_i      (CLK),
        .rst_ni     (RESET),
        .rd_index_i (lk_index),
        .rd_word_i  (lk_word),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (arr_we),
        .wr_index_i (arr_index),
        .wr_word_i  (arr_word),
        .wr_be_i    (arr_be),
        .wr_data_i  (arr_wdata),
        .tag_set_i  (arr_tag_set),
        .tag_i      (mem_addr_q[31:TAG_LSB]),
        .inval_i    (arr_inval)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        FREEZE      = 1'b0;
        arr_we      = 1'b0;
        arr_index   = mem_addr_q[TAG_LSB-1:IDX_LSB];
        arr_word    = beat_q;
        arr_be      = 4'b0000;
        arr_wdata   = mem_rdata;
        arr_tag_set = 1'b0;
        arr_inval   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MemWrite_fMEM) begin
                    FREEZE      = 1'b1;
                    state_d     = ST_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {data_address_fMEM[31:2], 2'b00};
                    mem_wdata_d = store_lanes(ALU_control_fMEM, data_write_fMEM);
                    mem_be_d    = store_be(ALU_control_fMEM, data_address_fMEM[1:0]);
                end else if (MemRead_fMEM && !hit) begin
                    FREEZE     = 1'b1;
                    state_d    = ST_FILL;
                    beat_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {data_address_fMEM[31:IDX_LSB], {IDX_LSB{1'b0}}};
                    // Drop the victim's valid bit now so an aborted fill can
                    // never leave a half-overwritten line looking valid.
                    arr_index  = data_address_fMEM[TAG_LSB-1:IDX_LSB];
                    arr_inval  = 1'b1;
                end
            end

            ST_FILL: begin
                FREEZE = 1'b1;
                if (ack) begin
                    arr_we = 1'b1;
                    arr_be = 4'b1111;
                    if (beat_q == WORD_BITS'(LINE_WORDS - 1)) begin
                        arr_tag_set = 1'b1;
                        state_d     = ST_IDLE;
                        beat_d      = '0;
                        mem_req_d   = 1'b0;
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        mem_addr_d = mem_addr_q + 32'd4;
                    end
                end
            end

            ST_WRITE: begin
                FREEZE = 1'b1;
                if (ack) begin
                    // Write-through, no allocate: update the cached copy only
                    // when the line is already present.
                    arr_we    = hit;
                    arr_word  = mem_addr_q[IDX_LSB-1:2];
                    arr_be    = mem_be_q;
                    arr_wdata = mem_wdata_q;
                    state_d   = ST_WDONE;
                    mem_req_d = 1'b0;
                end
            end

            ST_WDONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign data_read_2MEM = rd_data;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_be         = mem_be_q;
    assign state_o        = state_q;

endmodule
